// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b PCS definitions: widths, running-disparity encoding, comma constants.
package pcs_8b10b_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CODE_W = 10;
  localparam int unsigned X_W    = 5;
  localparam int unsigned Y_W    = 3;
  localparam int unsigned SIX_W  = 6;
  localparam int unsigned FOUR_W = 4;

  // Running disparity: 0 = RD-, 1 = RD+
  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } rd_e;

  // Code group layout: [9:6] = fghj (f at bit 9), [5:0] = abcdei (a at bit 5)
  localparam logic [CODE_W-1:0] K28_5_RDN = 10'h28F;
  localparam logic [CODE_W-1:0] K28_5_RDP = 10'h170;

  localparam logic [X_W-1:0] K28_X = 5'd28;
  localparam logic [Y_W-1:0] K28_5_Y = 3'd5;

  // Byte/control pair presented to the encoder table
  typedef struct packed {
    logic              k;
    logic [DATA_W-1:0] data;
  } enc_in_t;

  // Encoder table result
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              rd;
    logic              err;
  } enc_out_t;

endpackage

// File: rtl/enc_8b10b_lut.sv
// Combinational 8b/10b encoder: 5b/6b and 3b/4b tables, K-code validity, next RD.
module enc_8b10b_lut
  import pcs_8b10b_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_k,
  input  logic              i_rd,
  output logic [CODE_W-1:0] o_code_c,
  output logic              o_rd_c,
  output logic              o_err_c
);

  // 5b/6b RD- column; MSB flags an unbalanced (4 ones) sub-block
  function automatic logic [SIX_W:0] six_rdn(input logic [X_W-1:0] x);
    logic [SIX_W:0] r;
    r = {1'b0, 6'b000000};
    case (x)
      5'd0:  r = {1'b1, 6'b100111};
      5'd1:  r = {1'b1, 6'b011101};
      5'd2:  r = {1'b1, 6'b101101};
      5'd3:  r = {1'b0, 6'b110001};
      5'd4:  r = {1'b1, 6'b110101};
      5'd5:  r = {1'b0, 6'b101001};
      5'd6:  r = {1'b0, 6'b011001};
      5'd7:  r = {1'b0, 6'b111000};
      5'd8:  r = {1'b1, 6'b111001};
      5'd9:  r = {1'b0, 6'b100101};
      5'd10: r = {1'b0, 6'b010101};
      5'd11: r = {1'b0, 6'b110100};
      5'd12: r = {1'b0, 6'b001101};
      5'd13: r = {1'b0, 6'b101100};
      5'd14: r = {1'b0, 6'b011100};
      5'd15: r = {1'b1, 6'b010111};
      5'd16: r = {1'b1, 6'b011011};
      5'd17: r = {1'b0, 6'b100011};
      5'd18: r = {1'b0, 6'b010011};
      5'd19: r = {1'b0, 6'b110010};
      5'd20: r = {1'b0, 6'b001011};
      5'd21: r = {1'b0, 6'b101010};
      5'd22: r = {1'b0, 6'b011010};
      5'd23: r = {1'b1, 6'b111010};
      5'd24: r = {1'b1, 6'b110011};
      5'd25: r = {1'b0, 6'b100110};
      5'd26: r = {1'b0, 6'b010110};
      5'd27: r = {1'b1, 6'b110110};
      5'd28: r = {1'b0, 6'b001110};
      5'd29: r = {1'b1, 6'b101110};
      5'd30: r = {1'b1, 6'b011110};
      5'd31: r = {1'b1, 6'b101011};
      default: r = {1'b0, 6'b000000};
    endcase
    return r;
  endfunction

  // 3b/4b data RD- column; MSB flags an unbalanced sub-block
  function automatic logic [FOUR_W:0] d4_rdn(input logic [Y_W-1:0] y, input logic a7);
    logic [FOUR_W:0] r;
    r = {1'b0, 4'b0000};
    case (y)
      3'd0: r = {1'b1, 4'b1011};
      3'd1: r = {1'b0, 4'b1001};
      3'd2: r = {1'b0, 4'b0101};
      3'd3: r = {1'b0, 4'b1100};
      3'd4: r = {1'b1, 4'b1101};
      3'd5: r = {1'b0, 4'b1010};
      3'd6: r = {1'b0, 4'b0110};
      3'd7: r = a7 ? {1'b1, 4'b0111} : {1'b1, 4'b1110};
      default: r = {1'b0, 4'b0000};
    endcase
    return r;
  endfunction

  // 3b/4b control RD- column; the RD+ column is always the complement
  function automatic logic [FOUR_W:0] k4_rdn(input logic [Y_W-1:0] y);
    logic [FOUR_W:0] r;
    r = {1'b0, 4'b0000};
    case (y)
      3'd0: r = {1'b1, 4'b1011};
      3'd1: r = {1'b0, 4'b0110};
      3'd2: r = {1'b0, 4'b1010};
      3'd3: r = {1'b0, 4'b1100};
      3'd4: r = {1'b1, 4'b1101};
      3'd5: r = {1'b0, 4'b0101};
      3'd6: r = {1'b0, 4'b1001};
      3'd7: r = {1'b1, 4'b0111};
      default: r = {1'b0, 4'b0000};
    endcase
    return r;
  endfunction

  logic [X_W-1:0]    w_x_raw;
  logic [Y_W-1:0]    w_y_raw;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic              w_k_ok;
  logic              w_k28;
  logic [SIX_W:0]    w_six_tab;
  logic [SIX_W-1:0]  w_six;
  logic              w_rd6;
  logic              w_a7;
  logic [FOUR_W:0]   w_four_tab;
  logic [FOUR_W-1:0] w_four;

  // Table lookup, with unsupported control codes replaced by K28.5
  always_comb begin
    w_x_raw    = i_data[X_W-1:0];
    w_y_raw    = i_data[DATA_W-1:X_W];
    w_k_ok     = (w_x_raw == K28_X) ||
                 ((w_y_raw == 3'd7) && ((w_x_raw == 5'd23) || (w_x_raw == 5'd27) ||
                                        (w_x_raw == 5'd29) || (w_x_raw == 5'd30)));
    o_err_c    = i_k & ~w_k_ok;
    w_x        = o_err_c ? K28_X   : w_x_raw;
    w_y        = o_err_c ? K28_5_Y : w_y_raw;
    w_k28      = i_k & (w_x == K28_X);

    // 6b: complement at RD+ for unbalanced codes and for D.7
    w_six_tab  = w_k28 ? {1'b1, 6'b001111} : six_rdn(w_x);
    w_six      = (i_rd & (w_six_tab[SIX_W] | (w_x == 5'd7))) ? ~w_six_tab[SIX_W-1:0]
                                                             : w_six_tab[SIX_W-1:0];
    w_rd6      = i_rd ^ w_six_tab[SIX_W];

    // 4b: alternate A7 avoids a run of five across the sub-block boundary
    w_a7       = (~w_rd6 & ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) |
                 ( w_rd6 & ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));
    w_four_tab = i_k ? k4_rdn(w_y) : d4_rdn(w_y, w_a7);
    w_four     = (w_rd6 & (i_k | w_four_tab[FOUR_W] | (w_y == 3'd3))) ? ~w_four_tab[FOUR_W-1:0]
                                                                      : w_four_tab[FOUR_W-1:0];

    o_code_c   = {w_four, w_six};
    o_rd_c     = w_rd6 ^ w_four_tab[FOUR_W];
  end

endmodule

// File: rtl/encoder_8b10b_tx.sv
// 8b/10b transmit encoder: one registered code group per cycle, optional idle comma insertion.
module encoder_8b10b_tx
  import pcs_8b10b_pkg::*;
#(
  parameter bit IDLE_COMMA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              k_in,
  input  logic              valid_in,
  output logic [CODE_W-1:0] data_out,
  output logic              valid_out,
  output logic              idle_out,
  output logic              rd_out,
  output logic              code_err
);

  enc_in_t           w_lut_in;
  logic [CODE_W-1:0] w_code;
  logic              w_rd_next;
  logic              w_err;

  rd_e               r_rd;
  logic [CODE_W-1:0] r_data;
  logic              r_valid;
  logic              r_idle;
  logic              r_err;

  // Pack the incoming byte for the table
  always_comb begin
    w_lut_in      = '0;
    w_lut_in.k    = k_in;
    w_lut_in.data = data_in;
  end

  enc_8b10b_lut u_lut (
    .i_data   (w_lut_in.data),
    .i_k      (w_lut_in.k),
    .i_rd     (r_rd == RD_POS),
    .o_code_c (w_code),
    .o_rd_c   (w_rd_next),
    .o_err_c  (w_err)
  );

  // Output and running-disparity registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= RD_NEG;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b0;
      r_err   <= 1'b0;
    end else if (valid_in) begin
      r_rd    <= rd_e'(w_rd_next);
      r_data  <= w_code;
      r_valid <= 1'b1;
      r_idle  <= 1'b0;
      r_err   <= w_err;
    end else if (IDLE_COMMA) begin
      // K28.5 always flips RD: unbalanced 6b, balanced 4b
      r_rd    <= (r_rd == RD_POS) ? RD_NEG : RD_POS;
      r_data  <= (r_rd == RD_POS) ? K28_5_RDP : K28_5_RDN;
      r_valid <= 1'b1;
      r_idle  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_idle  <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign idle_out  = r_idle;
  assign rd_out    = (r_rd == RD_POS);
  assign code_err  = r_err;

endmodule

// File: tb/tb_encoder_8b10b_tx.sv
// Directed and random-byte bench for encoder_8b10b_tx with an independent reverse-table decoder.
module tb_encoder_8b10b_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       k_in;
  logic       valid_in;

  logic [9:0] a_data;
  logic       a_valid, a_idle, a_rd, a_err;
  logic [9:0] h_data;
  logic       h_valid, h_idle, h_rd, h_err;

  int n_chk  = 0;
  int n_pass = 0;

  encoder_8b10b_tx #(.IDLE_COMMA(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .k_in(k_in), .valid_in(valid_in),
    .data_out(a_data), .valid_out(a_valid), .idle_out(a_idle), .rd_out(a_rd), .code_err(a_err)
  );

  encoder_8b10b_tx #(.IDLE_COMMA(1'b0)) u_dut_hold (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .k_in(k_in), .valid_in(valid_in),
    .data_out(h_data), .valid_out(h_valid), .idle_out(h_idle), .rd_out(h_rd), .code_err(h_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic expect_a(input string tag, input logic [9:0] d, input logic rd,
                          input logic v, input logic idl, input logic err);
    chk10({tag, ".data"}, a_data, d);
    chk1({tag, ".rd"}, a_rd, rd);
    chk1({tag, ".valid"}, a_valid, v);
    chk1({tag, ".idle"}, a_idle, idl);
    chk1({tag, ".err"}, a_err, err);
  endtask

  task automatic step(input logic v, input logic k, input logic [7:0] d);
    @(negedge clk);
    valid_in = v;
    k_in     = k;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Reverse lookup over both polarity columns; MSB set on an invalid sub-block
  function automatic logic [8:0] dec8b10b(input logic [9:0] c);
    logic [4:0] x;
    logic [2:0] y;
    logic       e6;
    logic       e4;
    x = 5'd0; y = 3'd0; e6 = 1'b0; e4 = 1'b0;
    case (c[5:0])
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              e6 = 1'b1;
    endcase
    case (c[9:6])
      4'b1011, 4'b0100:                   y = 3'd0;
      4'b1001:                            y = 3'd1;
      4'b0101:                            y = 3'd2;
      4'b1100, 4'b0011:                   y = 3'd3;
      4'b1101, 4'b0010:                   y = 3'd4;
      4'b1010:                            y = 3'd5;
      4'b0110:                            y = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: y = 3'd7;
      default:                            e4 = 1'b1;
    endcase
    return {e6 | e4, y, x};
  endfunction

  initial begin
    logic       m_rd;
    logic       exp_rd;
    logic       v;
    logic [7:0] b;
    int         ones;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    k_in     = 1'b0;
    data_in  = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    expect_a("rst", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk10("rst_hold.data", h_data, 10'h000);

    // Idle commas alternate polarity from RD-
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_a("idle0", 10'h28F, 1'b1, 1'b1, 1'b1, 1'b0);
    chk1("idle0_hold.valid", h_valid, 1'b0);
    chk10("idle0_hold.data", h_data, 10'h000);
    chk1("idle0_hold.rd", h_rd, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    expect_a("idle1", 10'h170, 1'b0, 1'b1, 1'b1, 1'b0);

    // Directed data and control characters
    step(1'b1, 1'b0, 8'h00);
    expect_a("D0.0", 10'h127, 1'b0, 1'b1, 1'b0, 1'b0);
    chk10("D0.0_hold.data", h_data, 10'h127);
    step(1'b1, 1'b0, 8'hB5);
    expect_a("D21.5", 10'h2AA, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hF1);
    expect_a("D17.7", 10'h1E3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hEB);
    expect_a("D11.7+", 10'h234, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hBC);
    expect_a("K28.5", 10'h28F, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hBC);
    expect_a("K28.5+", 10'h170, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h00);
    expect_a("Kbad", 10'h28F, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h63);
    expect_a("D3.3+", 10'h0F1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hF7);
    expect_a("K23.7+", 10'h1C5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h07);
    expect_a("D7.0+", 10'h107, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hFC);
    expect_a("K28.7", 10'h20F, 1'b0, 1'b1, 1'b0, 1'b0);

    // Gap: idle comma on one instance, hold on the other
    step(1'b0, 1'b0, 8'h00);
    expect_a("gap", 10'h28F, 1'b1, 1'b1, 1'b1, 1'b0);
    chk10("gap_hold.data", h_data, 10'h20F);
    chk1("gap_hold.valid", h_valid, 1'b0);
    chk1("gap_hold.idle", h_idle, 1'b0);
    chk1("gap_hold.rd", h_rd, 1'b0);
    chk1("gap_hold.err", h_err, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    expect_a("gap2", 10'h170, 1'b0, 1'b1, 1'b1, 1'b0);

    // Drive to RD+, then pulse reset mid-stream
    step(1'b1, 1'b0, 8'hF1);
    expect_a("pre_rst", 10'h1E3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_a("mid_rst", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_a("mid_rst2", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    valid_in = 1'b1;
    k_in     = 1'b0;
    data_in  = 8'h00;
    @(posedge clk); #1;
    expect_a("post_rst", 10'h127, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random bytes with occasional gaps: decode round-trip and disparity tracking
    m_rd = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 15) != 0);
      b = 8'($urandom);
      step(v, 1'b0, b);
      if (v) chk10("rand.decode", 10'(dec8b10b(a_data)), 10'({1'b0, b}));
      else   chk10("rand.idle", a_data, m_rd ? 10'h170 : 10'h28F);
      ones = $countones(a_data);
      if (ones == 5)                exp_rd = m_rd;
      else if (ones == 6 && !m_rd)  exp_rd = 1'b1;
      else if (ones == 4 && m_rd)   exp_rd = 1'b0;
      else                          exp_rd = 1'bx;
      chk1("rand.rd", a_rd, exp_rd);
      m_rd = a_rd;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
